// File: rtl/pipe_reg_en_if.sv
// rtl/pipe_reg_en_if.sv - stage-chain bus: enable/flush/payload in, payload/valid/occupancy out
interface pipe_reg_en_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1
);
  localparam int OW = $clog2(DEPTH + 1);

  logic             en;
  logic             flush;
  logic [WIDTH-1:0] d;
  logic             valid_in;
  logic [WIDTH-1:0] q;
  logic             valid_out;
  logic [OW-1:0]    occ;

  modport master (
    output en, flush, d, valid_in,
    input  q, valid_out, occ
  );

  modport slave (
    input  en, flush, d, valid_in,
    output q, valid_out, occ
  );
endinterface

// File: rtl/pipe_reg_en.sv
// rtl/pipe_reg_en.sv - DEPTH-stage enabled pipeline register with flush, per-stage valid and occupancy
module pipe_reg_en #(
  parameter int               WIDTH   = 16,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic clk,
  input  logic rst,
  pipe_reg_en_if.slave bus
);
  localparam int OW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] data [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [OW-1:0]    occ_r;

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        data[i] <= RST_VAL;
      end
      vld   <= '0;
      occ_r <= '0;
    end else if (bus.en) begin
      data[0] <= bus.d;
      vld[0]  <= bus.valid_in;
      for (int i = 1; i < DEPTH; i++) begin
        data[i] <= data[i-1];
        vld[i]  <= vld[i-1];
      end
      // Modular arithmetic: the transient occ+1 at a full chain always pairs with a departing valid word.
      occ_r <= occ_r + OW'(bus.valid_in) - OW'(vld[DEPTH-1]);
    end
  end

  assign bus.q         = data[DEPTH-1];
  assign bus.valid_out = vld[DEPTH-1];
  assign bus.occ       = occ_r;

  occ_tracks_valid_bits: assert property (
    @(posedge clk) disable iff (rst) occ_r == OW'($countones(vld))
  );
endmodule

// File: tb/tb_pipe_reg_en.sv
// tb/tb_pipe_reg_en.sv - directed self-checking bench for pipe_reg_en (DEPTH=3 x2 reset values, DEPTH=1)
module tb_pipe_reg_en;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipe_reg_en_if #(.WIDTH(16), .DEPTH(3)) ia ();
  pipe_reg_en_if #(.WIDTH(16), .DEPTH(3)) ib ();
  pipe_reg_en_if #(.WIDTH(16), .DEPTH(1)) ic ();

  pipe_reg_en #(.WIDTH(16), .DEPTH(3), .RST_VAL(16'h0000)) u_a (.clk(clk), .rst(rst), .bus(ia));
  pipe_reg_en #(.WIDTH(16), .DEPTH(3), .RST_VAL(16'h0800)) u_b (.clk(clk), .rst(rst), .bus(ib));
  pipe_reg_en #(.WIDTH(16), .DEPTH(1), .RST_VAL(16'h0000)) u_c (.clk(clk), .rst(rst), .bus(ic));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic e, input logic f, input logic [15:0] dd, input logic v);
    ia.en = e; ia.flush = f; ia.d = dd; ia.valid_in = v;
    ib.en = e; ib.flush = f; ib.d = dd; ib.valid_in = v;
    ic.en = e; ic.flush = f; ic.d = dd; ic.valid_in = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_in(1'b0, 1'b0, 16'h0000, 1'b0);
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_in(1'b1, 1'b0, 16'h1234, 1'b1);
    repeat (3) tick();
    rst = 1'b1;
    set_in(1'b1, 1'b0, 16'hFFFF, 1'b1);
    tick();
    rst = 1'b0;
    set_in(1'b0, 1'b0, 16'h0000, 1'b0);
    checks++; if (ia.q !== 16'h0000) begin errors++; $display("FAIL reset_q_a got %h exp %h", ia.q, 16'h0000); end
    checks++; if (ia.valid_out !== 1'b0) begin errors++; $display("FAIL reset_vo_a got %b exp 0", ia.valid_out); end
    checks++; if (ia.occ !== 2'd0) begin errors++; $display("FAIL reset_occ_a got %0d exp 0", ia.occ); end
    checks++; if (ib.q !== 16'h0800) begin errors++; $display("FAIL reset_q_b got %h exp %h", ib.q, 16'h0800); end
    checks++; if (ic.q !== 16'h0000 || ic.valid_out !== 1'b0 || ic.occ !== 1'b0) begin
      errors++; $display("FAIL reset_c got q=%h vo=%b occ=%b exp q=0000 vo=0 occ=0", ic.q, ic.valid_out, ic.occ);
    end
  endtask

  task automatic test_streaming();
    logic [15:0] w   [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    logic [15:0] eq  [4] = '{16'h0000, 16'h0000, 16'h1111, 16'h2222};
    logic        evo [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [1:0]  eoc [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 1'b0, w[i], 1'b1);
      tick();
      checks++; if (ia.q !== eq[i]) begin errors++; $display("FAIL stream_q[%0d] got %h exp %h", i, ia.q, eq[i]); end
      checks++; if (ia.valid_out !== evo[i]) begin errors++; $display("FAIL stream_vo[%0d] got %b exp %b", i, ia.valid_out, evo[i]); end
      checks++; if (ia.occ !== eoc[i]) begin errors++; $display("FAIL stream_occ[%0d] got %0d exp %0d", i, ia.occ, eoc[i]); end
    end
  endtask

  task automatic test_stall();
    logic [15:0] eq  [3] = '{16'h0000, 16'h1111, 16'h0000};
    logic        evo [3] = '{1'b0, 1'b1, 1'b0};
    logic [1:0]  eoc [3] = '{2'd1, 2'd1, 2'd0};
    do_reset();
    set_in(1'b1, 1'b0, 16'h1111, 1'b1);
    tick();
    for (int i = 0; i < 5; i++) begin
      set_in(1'b0, 1'b0, 16'hDEAD, 1'b1);
      tick();
      checks++; if (ia.q !== 16'h0000 || ia.valid_out !== 1'b0 || ia.occ !== 2'd1) begin
        errors++; $display("FAIL stall_hold[%0d] got q=%h vo=%b occ=%0d exp q=0000 vo=0 occ=1", i, ia.q, ia.valid_out, ia.occ);
      end
    end
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 1'b0, 16'h0000, 1'b0);
      tick();
      checks++; if (ia.q !== eq[i] || ia.valid_out !== evo[i] || ia.occ !== eoc[i]) begin
        errors++; $display("FAIL stall_resume[%0d] got q=%h vo=%b occ=%0d exp q=%h vo=%b occ=%0d",
                           i, ia.q, ia.valid_out, ia.occ, eq[i], evo[i], eoc[i]);
      end
    end
  endtask

  task automatic test_flush();
    do_reset();
    set_in(1'b1, 1'b0, 16'h5555, 1'b1);
    repeat (3) tick();
    checks++; if (ia.occ !== 2'd3 || ia.valid_out !== 1'b1) begin
      errors++; $display("FAIL flush_fill got occ=%0d vo=%b exp occ=3 vo=1", ia.occ, ia.valid_out);
    end
    set_in(1'b0, 1'b1, 16'h7777, 1'b1);
    tick();
    checks++; if (ia.q !== 16'h0000 || ia.valid_out !== 1'b0 || ia.occ !== 2'd0) begin
      errors++; $display("FAIL flush_a got q=%h vo=%b occ=%0d exp q=0000 vo=0 occ=0", ia.q, ia.valid_out, ia.occ);
    end
    checks++; if (ib.q !== 16'h0800 || ib.valid_out !== 1'b0 || ib.occ !== 2'd0) begin
      errors++; $display("FAIL flush_b got q=%h vo=%b occ=%0d exp q=0800 vo=0 occ=0", ib.q, ib.valid_out, ib.occ);
    end
    set_in(1'b1, 1'b1, 16'h7777, 1'b1);
    tick();
    checks++; if (ia.occ !== 2'd0) begin errors++; $display("FAIL flush_en_discard got occ=%0d exp 0", ia.occ); end
    set_in(1'b1, 1'b0, 16'h0000, 1'b0);
    repeat (3) tick();
    checks++; if (ia.q !== 16'h0000 || ia.valid_out !== 1'b0 || ia.occ !== 2'd0) begin
      errors++; $display("FAIL flush_drain got q=%h vo=%b occ=%0d exp q=0000 vo=0 occ=0", ia.q, ia.valid_out, ia.occ);
    end
  endtask

  task automatic test_bubbles();
    logic [15:0] w   [6] = '{16'hA001, 16'hA002, 16'hA003, 16'hA004, 16'h0000, 16'h0000};
    logic        vin [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [15:0] eq  [6] = '{16'h0000, 16'h0000, 16'hA001, 16'hA002, 16'hA003, 16'hA004};
    logic        evo [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [1:0]  eoc [6] = '{2'd1, 2'd1, 2'd2, 2'd1, 2'd1, 2'd0};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      set_in(1'b1, 1'b0, w[i], vin[i]);
      tick();
      checks++; if (ia.q !== eq[i] || ia.valid_out !== evo[i] || ia.occ !== eoc[i]) begin
        errors++; $display("FAIL bubble[%0d] got q=%h vo=%b occ=%0d exp q=%h vo=%b occ=%0d",
                           i, ia.q, ia.valid_out, ia.occ, eq[i], evo[i], eoc[i]);
      end
    end
  endtask

  task automatic test_priority();
    do_reset();
    set_in(1'b1, 1'b0, 16'h3C3C, 1'b1);
    repeat (3) tick();
    rst = 1'b1;
    set_in(1'b1, 1'b1, 16'hBEEF, 1'b1);
    tick();
    rst = 1'b0;
    set_in(1'b0, 1'b0, 16'h0000, 1'b0);
    checks++; if (ia.q !== 16'h0000 || ia.valid_out !== 1'b0 || ia.occ !== 2'd0) begin
      errors++; $display("FAIL prio_a got q=%h vo=%b occ=%0d exp q=0000 vo=0 occ=0", ia.q, ia.valid_out, ia.occ);
    end
    checks++; if (ib.q !== 16'h0800) begin errors++; $display("FAIL prio_b got q=%h exp 0800", ib.q); end
  endtask

  task automatic test_depth1();
    logic        en_v [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic        fl_v [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [15:0] w    [5] = '{16'h0042, 16'h0099, 16'h0077, 16'h0055, 16'h0066};
    logic        vin  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [15:0] eq   [5] = '{16'h0042, 16'h0042, 16'h0077, 16'h0055, 16'h0000};
    logic        evo  [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_in(en_v[i], fl_v[i], w[i], vin[i]);
      tick();
      checks++; if (ic.q !== eq[i] || ic.valid_out !== evo[i] || ic.occ !== evo[i]) begin
        errors++; $display("FAIL depth1[%0d] got q=%h vo=%b occ=%b exp q=%h vo=%b occ=%b",
                           i, ic.q, ic.valid_out, ic.occ, eq[i], evo[i], evo[i]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t exp finish earlier", $time);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    set_in(1'b0, 1'b0, 16'h0000, 1'b0);
    repeat (2) tick();
    test_reset();
    test_streaming();
    test_stall();
    test_flush();
    test_bubbles();
    test_priority();
    test_depth1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
